// File: rtl/ysyx_23060208_axil_pkg.sv
// Shared AXI-Lite initiator definitions: FSM state encoding and response codes,
// used by both the write and read initiators.
package ysyx_23060208_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_AW = 3'd2,
        WAIT_W  = 3'd3,
        WAIT_B  = 3'd4
    } axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060208_axil_watchdog.sv
// Saturating cycle counter with clear/enable and a sticky flag raised when the
// count reaches LIMIT; the flag is cleared only by reset.
module ysyx_23060208_axil_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic flag
);

    localparam int unsigned WIDTH = $clog2(LIMIT + 1);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (enable && (cnt != LIMIT_V)) begin
            cnt_next = cnt + WIDTH'(1);
        end
    end

    // Flag is set from the next count so it rises in the same cycle the count reaches LIMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            flag <= flag | (cnt_next == LIMIT_V);
        end
    end

endmodule

// File: rtl/ysyx_23060208_axil_wmaster.sv
// AXI-Lite write initiator: one outstanding LSU store, AW/W issued together, B returned
// as a one-cycle done pulse. Optional watchdog: YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN.
module ysyx_23060208_axil_wmaster
    import ysyx_23060208_axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic [DATA_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    axil_state_e state;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;

    // All outputs are registered; req_ready mirrors "next state is IDLE" so it stays low in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_awaddr   <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            done_valid <= 1'b0;
            done_resp  <= RESP_OKAY;
        end else begin
            done_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        m_awaddr  <= req_addr;
                        m_wdata   <= req_data;
                        m_wstrb   <= req_wstrb;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (aw_hs && w_hs) begin
                        m_awvalid <= 1'b0;
                        m_wvalid  <= 1'b0;
                        m_bready  <= 1'b1;
                        state     <= WAIT_B;
                    end else if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        state     <= WAIT_W;
                    end else if (w_hs) begin
                        m_wvalid <= 1'b0;
                        state    <= WAIT_AW;
                    end
                end
                WAIT_AW: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        m_bready  <= 1'b1;
                        state     <= WAIT_B;
                    end
                end
                WAIT_W: begin
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        m_bready <= 1'b1;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_hs) begin
                        m_bready   <= 1'b0;
                        done_resp  <= m_bresp;
                        done_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
    ysyx_23060208_axil_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .enable(1'b1),
        .flag  (timeout)
    );
`else
    // TIMEOUT_CYCLES stays on the interface so builds with and without the watchdog share one footprint.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

endmodule

// File: tb/tb_ysyx_23060208_axil_wmaster.sv
// Directed self-checking bench for ysyx_23060208_axil_wmaster; the timeout scenario
// checks the flag when YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN is defined.
module tb_ysyx_23060208_axil_wmaster;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_wstrb;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int fails  = 0;

    ysyx_23060208_axil_wmaster #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_wstrb (req_wstrb),
        .done_valid(done_valid),
        .done_resp (done_resp),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status vector order: {req_ready, m_awvalid, m_wvalid, m_bready, done_valid}
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_wstrb = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        repeat (3) step();
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb, done_resp} !== 70'h0) begin
            fails++;
            $display("FAIL reset_payload: got %h expected 0", {m_awaddr, m_wdata, m_wstrb, done_resp});
        end
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_timeout: got %b expected 0", timeout);
        end
`endif
        rst_n = 1'b1;
        step();
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b10000) begin
            fails++;
            $display("FAIL post_reset_ready: got %b expected 10000",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
    endtask

    task automatic test_single_write();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h1000_03F8; req_data = 32'h0000_0041; req_wstrb = 4'b0001;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_ready_before: got %b expected 1", req_ready);
        end
        step();                           // edge N: accept
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b01100) begin
            fails++;
            $display("FAIL single_n1_ctrl: got %b expected 01100",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb} !== {32'h1000_03F8, 32'h0000_0041, 4'b0001}) begin
            fails++;
            $display("FAIL single_payload: got %h %h %b expected 100003f8 00000041 0001",
                     m_awaddr, m_wdata, m_wstrb);
        end
        step();                           // N+2
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b00010) begin
            fails++;
            $display("FAIL single_n2_bready: got %b expected 00010",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
        m_bvalid = 1'b1; m_bresp = 2'b00;
        step();                           // N+3
        m_bvalid = 1'b0; m_bresp = 2'b11;
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid, done_resp} !== 7'b1000100) begin
            fails++;
            $display("FAIL single_n3_done: got %b expected 1000100",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid, done_resp});
        end
        step();
        checks++;
        if (done_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_done_pulse: got %b expected 0", done_valid);
        end
    endtask

    task automatic test_aw_delay();
        m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0102; req_data = 32'hA5A5_0F0F; req_wstrb = 4'b0000;
        step();                           // edge N: accept
        req_valid = 1'b0; req_addr = '0; req_data = '0;
        checks++;
        if ({m_awvalid, m_wvalid} !== 2'b11) begin
            fails++;
            $display("FAIL awdly_n1_valids: got %b expected 11", {m_awvalid, m_wvalid});
        end
        for (int c = 2; c <= 6; c++) begin
            step();                       // cycle N+c
            checks++;
            if ({m_awvalid, m_wvalid, m_bready, m_awaddr, m_wstrb} !== {3'b100, 32'h0000_0102, 4'b0000}) begin
                fails++;
                $display("FAIL awdly_hold_c%0d: got %b %b %b %h %b expected 1 0 0 00000102 0000",
                         c, m_awvalid, m_wvalid, m_bready, m_awaddr, m_wstrb);
            end
            if (c == 6) m_awready = 1'b1;
        end
        step();                           // N+7
        m_awready = 1'b0;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, done_valid} !== 4'b0010) begin
            fails++;
            $display("FAIL awdly_bready: got %b expected 0010", {m_awvalid, m_wvalid, m_bready, done_valid});
        end
        m_bvalid = 1'b1; m_bresp = 2'b11;
        step();
        m_bvalid = 1'b0;
        checks++;
        if ({done_valid, done_resp, req_ready} !== 4'b1111) begin
            fails++;
            $display("FAIL awdly_done: got %b expected 1111", {done_valid, done_resp, req_ready});
        end
        step();
    endtask

    task automatic test_bresp_err();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h2000_0000; req_data = 32'h0000_1234; req_wstrb = 4'b1100;
        step();                           // N
        req_valid = 1'b0;
        step();                           // N+2: bready up
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({m_bready, done_valid} !== 2'b10) begin
                fails++;
                $display("FAIL slverr_wait%0d: got %b expected 10", c, {m_bready, done_valid});
            end
            step();
        end
        m_bvalid = 1'b1; m_bresp = 2'b10;
        step();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        checks++;
        if ({done_valid, done_resp, req_ready, m_bready} !== 5'b11010) begin
            fails++;
            $display("FAIL slverr_done: got %b expected 11010", {done_valid, done_resp, req_ready, m_bready});
        end
        step();
        checks++;
        if ({done_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL slverr_single_pulse: got %b expected 01", {done_valid, req_ready});
        end
    endtask

    task automatic test_back_to_back();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_data = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        step();                           // edge N: first accepted
        req_addr = 32'h8000_0004; req_data = 32'h1234_5678; req_wstrb = 4'b0011;
        checks++;
        if ({req_ready, m_awaddr, m_wdata, m_wstrb} !== {1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF}) begin
            fails++;
            $display("FAIL b2b_first_payload: got %b %h %h %b expected 0 80000000 deadbeef 1111",
                     req_ready, m_awaddr, m_wdata, m_wstrb);
        end
        step();                           // N+2
        m_bvalid = 1'b1; m_bresp = 2'b00;
        step();                           // N+3: done, second accepted at end of this cycle
        m_bvalid = 1'b0;
        checks++;
        if ({done_valid, req_ready, m_awvalid} !== 3'b110) begin
            fails++;
            $display("FAIL b2b_done_ready: got %b expected 110", {done_valid, req_ready, m_awvalid});
        end
        step();                           // N+4
        req_valid = 1'b0;
        checks++;
        if ({done_valid, m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb} !==
            {3'b011, 32'h8000_0004, 32'h1234_5678, 4'b0011}) begin
            fails++;
            $display("FAIL b2b_second_payload: got %b %b %b %h %h %b expected 0 1 1 80000004 12345678 0011",
                     done_valid, m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb);
        end
        step();
        m_bvalid = 1'b1; m_bresp = 2'b11;
        step();
        m_bvalid = 1'b0;
        checks++;
        if ({done_valid, done_resp} !== 3'b111) begin
            fails++;
            $display("FAIL b2b_second_done: got %b expected 111", {done_valid, done_resp});
        end
        step();
    endtask

    task automatic test_reset_mid();
        m_awready = 1'b1; m_wready = 1'b0; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h3000_0010; req_data = 32'h0BAD_F00D; req_wstrb = 4'hF;
        step();                           // N
        req_valid = 1'b0;
        step();                           // N+2: in WAIT_W
        checks++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin
            fails++;
            $display("FAIL rstmid_wait_w: got %b expected 010", {m_awvalid, m_wvalid, m_bready});
        end
        rst_n = 1'b0;
        m_bvalid = 1'b1;
        step();
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b00000) begin
            fails++;
            $display("FAIL rstmid_clear: got %b expected 00000",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
        rst_n = 1'b1; m_bvalid = 1'b0; m_wready = 1'b1;
        step();
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, done_valid} !== 5'b10000) begin
            fails++;
            $display("FAIL rstmid_release: got %b expected 10000",
                     {req_ready, m_awvalid, m_wvalid, m_bready, done_valid});
        end
    endtask

    task automatic test_timeout();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h4000_0000; req_data = 32'h0000_00FF; req_wstrb = 4'b0001;
        step();                           // edge N: cycle N+1
        req_valid = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            checks++;
            if ({m_bready, done_valid} !== {(c >= 2), 1'b0}) begin
                fails++;
                $display("FAIL tmo_wait_c%0d: got %b expected %b", c, {m_bready, done_valid}, {(c >= 2), 1'b0});
            end
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
            if (c == 16 || c == 17) begin
                checks++;
                if (timeout !== (c == 17)) begin
                    fails++;
                    $display("FAIL tmo_flag_c%0d: got %b expected %b", c, timeout, (c == 17));
                end
            end
`endif
            step();
        end
        m_bvalid = 1'b1; m_bresp = 2'b00;
        step();
        m_bvalid = 1'b0;
        checks++;
        if ({done_valid, done_resp, req_ready} !== 4'b1001) begin
            fails++;
            $display("FAIL tmo_done: got %b expected 1001", {done_valid, done_resp, req_ready});
        end
`ifdef YSYX_23060208_AXIL_WMASTER_TIMEOUT_EN
        step();
        checks++;
        if (timeout !== 1'b1) begin
            fails++;
            $display("FAIL tmo_sticky: got %b expected 1", timeout);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL tmo_reset_clear: got %b expected 0", timeout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_aw_delay();
        test_bresp_err();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
